// File: rtl/bcd_scan_display.sv
// bcd_scan_display: two-digit multiplexed seven-segment driver for the BCD
// ping-pong counter. Captures {d1,d0} once per display frame, scans the two
// digits onto an active-low segment bus and shows the count direction on the
// decimal point during the ones slot.
//
// Optional feature macro: BCD_SCAN_LZB_EN (leading-zero blanking of the tens
// digit). The default build leaves it undefined.
module bcd_scan_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       dp
);

  // Slot counter width; REFRESH_DIV is at least 2 so this is at least 1.
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  // Direction encoding held in dir_q.
  localparam logic [0:0] DIR_UP   = 1'b0;
  localparam logic [0:0] DIR_DOWN = 1'b1;

  // Segment patterns, active-low {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  // Scan state
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_q, sel_d;

  // Frame snapshot and direction tracking
  logic [7:0]    shadow_q, shadow_d;
  logic [0:0]    dir_q, dir_d;

  // Registered outputs
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          dp_q, dp_d;

  // Derived control
  logic          cnt_last;
  logic          frame_start;
  logic [7:0]    new_value;
  logic [3:0]    digit;
  logic          blank_tens;
  logic [6:0]    digit_seg;

  // Seven-segment decode; anything outside 0..9 shows a lone dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  assign cnt_last    = (cnt_q == CNT_LAST);
  assign frame_start = (cnt_q == '0) && !sel_q;
  assign new_value   = {d1, d0};

  // Slot counter advances every cycle and flips the digit select at wrap.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    sel_d = sel_q;
    if (cnt_last) begin
      cnt_d = '0;
      sel_d = ~sel_q;
    end
  end

  // Snapshot inputs and update direction only at the start of a frame, so
  // both digits shown within one frame always belong to the same capture.
  always_comb begin
    shadow_d = shadow_q;
    dir_d    = dir_q;
    if (frame_start) begin
      shadow_d = new_value;
      if (new_value > shadow_q) begin
        dir_d = DIR_UP;
      end else if (new_value < shadow_q) begin
        dir_d = DIR_DOWN;
      end
    end
  end

`ifdef BCD_SCAN_LZB_EN
  // Blank the tens slot when the captured tens digit is zero.
  assign blank_tens = sel_q && (shadow_q[7:4] == 4'd0);
`else
  assign blank_tens = 1'b0;
`endif

  assign digit     = sel_q ? shadow_q[7:4] : shadow_q[3:0];
  assign digit_seg = bcd_to_seg(digit);

  // One active-low anode per digit slot: an[0] for ones (sel=0), an[1] for tens.
  for (genvar gi = 0; gi < 2; gi++) begin : g_anode
    assign an_d[gi] = (sel_q != 1'(gi));
  end

  // Output stage loads from the pre-edge select, snapshot and direction.
  always_comb begin
    seg_d = blank_tens ? SEG_OFF : digit_seg;
    dp_d  = !(!sel_q && (dir_q == DIR_DOWN));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      sel_q    <= 1'b0;
      shadow_q <= 8'h00;
      dir_q    <= DIR_UP;
      seg_q    <= SEG_OFF;
      an_q     <= 2'b11;
      dp_q     <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      dir_q    <= dir_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      dp_q     <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Testbench for bcd_scan_display with REFRESH_DIV=4. A frame-level reference
// model (edge count since reset, frame position by modulo arithmetic, a
// decode table) predicts seg/an/dp after every edge; directed checks follow
// the scenarios for reset, steady digits, direction, mid-frame change,
// invalid digit and leading zero, then a randomized run with a mid-run reset.
// Honours BCD_SCAN_LZB_EN when the design is built with it.
module tb_bcd_scan_display;

  localparam int RDIV  = 4;
  localparam int FRAME = 2 * RDIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] d0  = 4'd0;
  logic [3:0] d1  = 4'd0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dp;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  int         edge_n   = 0;      // edges since reset release
  logic [7:0] m_shadow = 8'h00;
  bit         m_down   = 1'b0;
  logic [6:0] e_seg    = 7'h7F;
  logic [1:0] e_an     = 2'b11;
  logic       e_dp     = 1'b1;

  logic [6:0] dec_tbl [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
                                 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

`ifdef BCD_SCAN_LZB_EN
  bit         lzb       = 1'b1;
  logic [6:0] tens0_seg = 7'h7F;
`else
  bit         lzb       = 1'b0;
  logic [6:0] tens0_seg = 7'h40;
`endif

  bcd_scan_display #(.REFRESH_DIV(RDIV)) dut (
    .clk (clk),
    .rst (rst),
    .d0  (d0),
    .d1  (d1),
    .seg (seg),
    .an  (an),
    .dp  (dp)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock edge: advance the model with the inputs present at the edge,
  // then compare all outputs 1 time unit later.
  task automatic tick();
    int  p;
    bit  tens;
    logic [3:0] dg;
    logic [7:0] v;
    @(posedge clk);
    if (rst) begin
      edge_n   = 0;
      m_shadow = 8'h00;
      m_down   = 1'b0;
      e_seg    = 7'h7F;
      e_an     = 2'b11;
      e_dp     = 1'b1;
    end else begin
      p    = edge_n % FRAME;
      tens = (p >= RDIV);
      dg   = tens ? m_shadow[7:4] : m_shadow[3:0];
      e_an = tens ? 2'b01 : 2'b10;
      e_seg = (tens && lzb && dg == 4'd0) ? 7'h7F : dec_tbl[dg];
      e_dp  = (!tens && m_down) ? 1'b0 : 1'b1;
      if (p == 0) begin
        v = {d1, d0};
        if (v > m_shadow) m_down = 1'b0;
        else if (v < m_shadow) m_down = 1'b1;
        m_shadow = v;
      end
      edge_n++;
    end
    #1;
    check("seg", {1'b0, seg}, {1'b0, e_seg});
    check("an",  {6'b0, an},  {6'b0, e_an});
    check("dp",  {7'b0, dp},  {7'b0, e_dp});
    $display("edge %0d rst=%0b in=%h%h seg=%h an=%b dp=%b", edge_n, rst, d1, d0, seg, an, dp);
  endtask

  // Advance until the next edge is a frame start.
  task automatic align();
    while ((edge_n % FRAME) != 0) tick();
  endtask

  // Run one whole frame showing {t,o}; check dp in the ones slot.
  task automatic frame_dp(input logic [3:0] t, input logic [3:0] o, input logic exp_dp, input string tag);
    align();
    d1 = t; d0 = o;
    tick(); tick();
    check(tag, {7'b0, dp}, {7'b0, exp_dp});
    repeat (FRAME - 2) tick();
  endtask

  initial begin
    // Reset held for three cycles
    rst = 1'b1; d1 = 4'd4; d0 = 4'd2;
    repeat (3) tick();
    check("rst_seg", {1'b0, seg}, 8'h7F);
    check("rst_an",  {6'b0, an},  8'h03);
    check("rst_dp",  {7'b0, dp},  8'h01);
    rst = 1'b0;

    // Edge 2 after release shows the ones digit of the first capture
    tick(); tick();
    check("rel_an",  {6'b0, an},  8'h02);
    check("rel_seg", {1'b0, seg}, 8'h24);

    // Steady 42: tens slot shows 4
    repeat (4) tick();
    check("steady_tens_an",  {6'b0, an},  8'h01);
    check("steady_tens_seg", {1'b0, seg}, 8'h19);
    repeat (3 * FRAME) tick();

    // Direction: 03 -> 05 -> 04 -> 04 -> 06
    frame_dp(4'd0, 4'd3, 1'b0, "dir_03");
    frame_dp(4'd0, 4'd5, 1'b1, "dir_05");
    frame_dp(4'd0, 4'd4, 1'b0, "dir_04a");
    frame_dp(4'd0, 4'd4, 1'b0, "dir_04b");
    frame_dp(4'd0, 4'd6, 1'b1, "dir_06");

    // Mid-frame change: 3 -> 7 during the tens slot
    align();
    d1 = 4'd0; d0 = 4'd3;
    repeat (RDIV + 1) tick();
    d0 = 4'd7;
    repeat (RDIV - 1) tick();
    tick();
    check("mid_hold", {1'b0, seg}, 8'h30);
    tick();
    check("mid_new",  {1'b0, seg}, 8'h78);

    // Invalid ones digit
    align();
    d1 = 4'd1; d0 = 4'hC;
    tick(); tick();
    check("invalid", {1'b0, seg}, 8'h3F);
    repeat (FRAME - 2) tick();

    // Leading zero
    align();
    d1 = 4'd0; d0 = 4'd5;
    tick(); tick();
    check("lz_ones", {1'b0, seg}, 8'h12);
    repeat (RDIV) tick();
    check("lz_tens", {1'b0, seg}, {1'b0, tens0_seg});
    repeat (FRAME - RDIV - 2) tick();

    // Randomized inputs changing at arbitrary cycles
    for (int i = 0; i < 240; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        d0 = 4'($urandom_range(0, 15));
        d1 = 4'($urandom_range(0, 15));
      end
      tick();
    end

    // Reset in the middle of a frame, then resume random stimulus
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    d1 = 4'd2; d0 = 4'd1;
    tick(); tick();
    check("rst2_an",  {6'b0, an},  8'h02);
    check("rst2_seg", {1'b0, seg}, 8'h79);
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        d0 = 4'($urandom_range(0, 9));
        d1 = 4'($urandom_range(0, 9));
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
